// File: rtl/serdes_ddly_loader.sv
// Loads requested IDELAY tap values into the ADC LVDS lanes one lane at a time
// and flags lanes whose readback does not match after a settle interval.
module serdes_ddly_loader #(
  parameter int                    LANES    = 5,
  parameter int                    TAPW     = 5,
  parameter int                    SETTLE   = 4,
  parameter logic [LANES*TAPW-1:0] DEF_DDLY = 25'h6318c6
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [LANES*TAPW-1:0]   ser_ddly_i,
  input  logic                    new_ddly_i,
  input  logic                    idly_rdy_i,
  input  logic [LANES*TAPW-1:0]   idly_cntval_i,
  output logic [LANES*TAPW-1:0]   idly_cnt_o,
  output logic [LANES-1:0]        idly_ld_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [LANES-1:0]        mism_o
);

  localparam int              W           = LANES * TAPW;
  localparam int              LW          = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0]   LAST_LANE   = LW'(LANES - 1);
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_CHECK = 3'd4,
    ST_FIN   = 3'd5
  } state_e;

  state_e           state_r;
  state_e           state_nxt_s;
  logic [LW-1:0]    lane_r;
  logic [LW-1:0]    lane_nxt_s;
  logic [3:0]       wcnt_r;
  logic [3:0]       wcnt_nxt_s;
  logic [W-1:0]     shd_r;
  logic [W-1:0]     pnd_r;
  logic             pf_r;
  logic [LANES-1:0] ld_r;
  logic [LANES-1:0] ld_nxt_s;
  logic [LANES-1:0] mism_r;
  logic [LANES-1:0] mism_nxt_s;
  logic [LANES-1:0] cmp_s;
  logic             busy_r;
  logic             done_r;
  logic             start_s;
  logic             abort_s;

  // Per-lane readback compare against the shadow taps
  always_comb begin
    cmp_s = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      cmp_s[i] = (idly_cntval_i[i*TAPW +: TAPW] != shd_r[i*TAPW +: TAPW]);
    end
  end

  // Next-state, lane/counter update and load-strobe decode
  always_comb begin
    state_nxt_s = state_r;
    lane_nxt_s  = lane_r;
    wcnt_nxt_s  = wcnt_r;
    mism_nxt_s  = mism_r;
    start_s     = 1'b0;
    abort_s     = 1'b0;
    ld_nxt_s    = {LANES{1'b0}};

    case (state_r)
      ST_IDLE: begin
        if (pf_r && idly_rdy_i) begin
          state_nxt_s = ST_START;
          start_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (!idly_rdy_i) begin
          state_nxt_s = ST_IDLE;
          abort_s     = 1'b1;
        end else begin
          lane_nxt_s  = {LW{1'b0}};
          mism_nxt_s  = {LANES{1'b0}};
          state_nxt_s = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!idly_rdy_i) begin
          state_nxt_s = ST_IDLE;
          abort_s     = 1'b1;
        end else begin
          wcnt_nxt_s  = 4'd0;
          state_nxt_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!idly_rdy_i) begin
          state_nxt_s = ST_IDLE;
          abort_s     = 1'b1;
        end else if (wcnt_r == SETTLE_LAST) begin
          state_nxt_s = ST_CHECK;
        end else begin
          wcnt_nxt_s  = wcnt_r + 4'd1;
        end
      end
      ST_CHECK: begin
        if (!idly_rdy_i) begin
          state_nxt_s = ST_IDLE;
          abort_s     = 1'b1;
        end else begin
          mism_nxt_s[lane_r] = cmp_s[lane_r];
          if (lane_r == LAST_LANE) begin
            state_nxt_s = ST_FIN;
          end else begin
            lane_nxt_s  = lane_r + LW'(1);
            state_nxt_s = ST_LOAD;
          end
        end
      end
      ST_FIN: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // Strobe is registered, so decode it from the state being entered
    for (int i = 0; i < LANES; i++) begin
      if ((state_nxt_s == ST_LOAD) && (lane_nxt_s == LW'(i))) begin
        ld_nxt_s[i] = 1'b1;
      end else begin
        ld_nxt_s[i] = 1'b0;
      end
    end
  end

  // Sequencer state, lane index, settle counter and mismatch flags
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r <= ST_IDLE;
      lane_r  <= {LW{1'b0}};
      wcnt_r  <= 4'd0;
      mism_r  <= {LANES{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      lane_r  <= lane_nxt_s;
      wcnt_r  <= wcnt_nxt_s;
      mism_r  <= mism_nxt_s;
    end
  end

  // Pending request capture; a fresh request beats both abort and start
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pnd_r <= DEF_DDLY;
      pf_r  <= 1'b1;
    end else if (new_ddly_i) begin
      pnd_r <= ser_ddly_i;
      pf_r  <= 1'b1;
    end else if (abort_s) begin
      pnd_r <= shd_r;
      pf_r  <= 1'b1;
    end else if (start_s) begin
      pf_r  <= 1'b0;
    end else begin
      pf_r  <= pf_r;
    end
  end

  // Shadow taps presented to the delay primitives
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      shd_r <= DEF_DDLY;
    end else if (start_s) begin
      shd_r <= pnd_r;
    end else begin
      shd_r <= shd_r;
    end
  end

  // Registered status and strobe outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ld_r   <= {LANES{1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      ld_r   <= ld_nxt_s;
      busy_r <= (state_nxt_s != ST_IDLE);
      done_r <= (state_nxt_s == ST_FIN);
    end
  end

  assign idly_cnt_o = shd_r;
  assign idly_ld_o  = ld_r;
  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign mism_o     = mism_r;

endmodule

// File: tb/tb_serdes_ddly_loader.sv
// Scoreboard bench: the driver queues expected lane loads and done events from a
// lane-level model; a negedge monitor pops and checks them as the DUT emits them.
module tb_serdes_ddly_loader;

  localparam int              LANES    = 5;
  localparam int              TAPW     = 5;
  localparam int              SETTLE   = 4;
  localparam int              W        = LANES * TAPW;
  localparam logic [W-1:0]    DEF      = 25'h6318c6;
  localparam int              LANE_GAP = 2 + SETTLE;
  localparam int              SEQ_LAT  = 2 + LANES * (2 + SETTLE);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [W-1:0]     ser_ddly;
  logic             new_ddly;
  logic             rdy;
  logic [W-1:0]     cntval;
  logic [W-1:0]     idly_cnt;
  logic [LANES-1:0] idly_ld;
  logic             busy;
  logic             done;
  logic [LANES-1:0] mism;

  logic [LANES-1:0] force_en;
  logic [W-1:0]     force_val;

  typedef struct {
    bit               is_done;
    int               lane;
    logic [W-1:0]     taps;
    logic [LANES-1:0] mism;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  bit   busy_prev = 1'b0;

  serdes_ddly_loader #(
    .LANES(LANES), .TAPW(TAPW), .SETTLE(SETTLE), .DEF_DDLY(DEF)
  ) dut (
    .clk_i(clk), .rstn_i(rst_n), .ser_ddly_i(ser_ddly), .new_ddly_i(new_ddly),
    .idly_rdy_i(rdy), .idly_cntval_i(cntval), .idly_cnt_o(idly_cnt),
    .idly_ld_o(idly_ld), .busy_o(busy), .done_o(done), .mism_o(mism)
  );

  initial forever #5 clk = ~clk;

  // Delay primitive: echoes the presented taps unless a lane is forced
  always_comb begin
    cntval = idly_cnt;
    for (int n = 0; n < LANES; n++) begin
      if (force_en[n]) cntval[n*TAPW +: TAPW] = force_val[n*TAPW +: TAPW];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Lanes whose forced readback differs from the requested taps
  function automatic logic [LANES-1:0] model_mism(input logic [W-1:0] taps, input int nlanes);
    logic [LANES-1:0] m = '0;
    for (int n = 0; n < nlanes; n++)
      m[n] = force_en[n] && (force_val[n*TAPW +: TAPW] != taps[n*TAPW +: TAPW]);
    return m;
  endfunction

  task automatic push_seq(input logic [W-1:0] taps, input int nlanes, input bit with_done);
    exp_t e;
    for (int n = 0; n < nlanes; n++) begin
      e.is_done = 1'b0; e.lane = n; e.taps = taps; e.mism = '0;
      exp_q.push_back(e);
    end
    if (with_done) begin
      e.is_done = 1'b1; e.lane = LANES; e.taps = taps; e.mism = model_mism(taps, LANES);
      exp_q.push_back(e);
    end
  endtask

  task automatic request(input logic [W-1:0] taps);
    @(posedge clk); #1;
    ser_ddly = taps; new_ddly = 1'b1;
    @(posedge clk); #1;
    new_ddly = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    repeat (2) @(posedge clk);
    while ((busy || exp_q.size() != 0) && n < 400) begin
      @(posedge clk); n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s: timeout, %0d expected events outstanding", name, exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  task automatic wait_ld(input logic [LANES-1:0] val);
    int  n = 0;
    bit  hit = 1'b0;
    while (!hit && n < 200) begin
      @(posedge clk); #1; n++;
      if (idly_ld == val) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_ld: strobe %0h not seen, actual=%0h", val, idly_ld);
    end
  endtask

  // Monitor: pops expectations whenever the DUT strobes a load or signals done
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_prev = 1'b0;
      end else begin
        cyc++;
        if (busy && !busy_prev) begin
          start_cyc = cyc;
          if (exp_q.size() > 0) check("start_taps", idly_cnt, exp_q[0].taps);
        end
        busy_prev = busy;
        if (idly_ld != '0 || done) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event: actual ld=%0h done=%0b required none", idly_ld, done);
          end else begin
            e = exp_q.pop_front();
            if (!e.is_done) begin
              check("ld_strobe", {27'd0, idly_ld}, 32'(1) << e.lane);
              check("ld_done_low", {31'd0, done}, 32'd0);
              check("ld_taps", idly_cnt, e.taps);
              check("ld_time", cyc - start_cyc, 1 + e.lane * LANE_GAP);
              if (e.lane == 0) check("mism_clr", {27'd0, mism}, 32'd0);
            end else begin
              check("done_seen", {31'd0, done}, 32'd1);
              check("done_ld_low", {27'd0, idly_ld}, 32'd0);
              check("done_mism", {27'd0, mism}, {27'd0, e.mism});
              check("done_taps", idly_cnt, e.taps);
              check("done_lat", cyc - start_cyc + 1, SEQ_LAT);
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] t;
    logic [W-1:0] tc;
    logic [LANES-1:0] part;

    rst_n = 1'b0; rdy = 1'b1; new_ddly = 1'b0; ser_ddly = '0;
    force_en = '0; force_val = '0;
    #12;
    check("rst_ld", {27'd0, idly_ld}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_mism", {27'd0, mism}, 32'd0);
    check("rst_cnt", idly_cnt, DEF);

    // Automatic load of the default taps after reset
    push_seq(DEF, LANES, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_quiet("post_reset");

    // Single request, every lane 5'h10
    push_seq(25'h1084210, LANES, 1'b1);
    request(25'h1084210);
    wait_quiet("single");

    // Lane 2 reads back 0 while 5'h0C is requested
    t = W'($urandom());
    t[2*TAPW +: TAPW] = 5'h0C;
    force_en = 5'b00100; force_val = '0;
    push_seq(t, LANES, 1'b1);
    request(t);
    wait_quiet("mismatch");
    repeat (6) @(posedge clk);
    #1 check("mism_hold", {27'd0, mism}, 32'h4);
    force_en = '0;

    // Randomised requests with random forced lanes
    for (int k = 0; k < 6; k++) begin
      t = W'($urandom());
      force_en = LANES'($urandom_range(0, 31) & $urandom_range(0, 31));
      force_val = W'($urandom());
      push_seq(t, LANES, 1'b1);
      request(t);
      wait_quiet("random");
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    force_en = '0;

    // A runs; B then C arrive while busy; only C follows
    t = W'($urandom());
    tc = W'($urandom());
    push_seq(t, LANES, 1'b1);
    push_seq(tc, LANES, 1'b1);
    request(t);
    wait_ld(5'b00001);
    request(W'($urandom()));
    repeat (3) @(posedge clk);
    request(tc);
    wait_quiet("back_to_back");
    check("b2b_cnt", idly_cnt, tc);

    // Ready drops during lane 3 settle; lane 1 mismatches
    t = W'($urandom());
    force_en = 5'b00010; force_val = ~t;
    push_seq(t, 4, 1'b0);
    part = model_mism(t, 3);
    request(t);
    wait_ld(5'b01000);
    @(posedge clk); #1 rdy = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_mism", {27'd0, mism}, {27'd0, part});
    check("abort_q", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1 check("rdy_low_idle", {31'd0, busy}, 32'd0);
    push_seq(t, LANES, 1'b1);
    rdy = 1'b1;
    wait_quiet("ready_restart");
    force_en = '0;

    // Reset during lane 1 load
    t = W'($urandom());
    push_seq(t, 1, 1'b0);
    request(t);
    wait_ld(5'b00010);
    #1 rst_n = 1'b0;
    #1;
    check("arst_ld", {27'd0, idly_ld}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_cnt", idly_cnt, DEF);
    check("arst_q", exp_q.size(), 0);
    push_seq(DEF, LANES, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_quiet("reset_reload");

    repeat (4) @(posedge clk);
    check("final_q", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
